// File: rtl/bht_if.sv
// Branch history table port bundle: lookup request/response, training update and flush.
// The fetch/execute side uses the master modport; the predictor uses the slave modport.
interface bht_if #(
   parameter int unsigned PC_W = 32
) ();

   logic            flush;
   logic            lookup_valid;
   logic [PC_W-1:0] lookup_pc;
   logic            predict_valid;
   logic            predict_taken;
   logic            update_valid;
   logic [PC_W-1:0] update_pc;
   logic            update_taken;

   modport master (
      output flush,
      output lookup_valid,
      output lookup_pc,
      output update_valid,
      output update_pc,
      output update_taken,
      input  predict_valid,
      input  predict_taken
   );

   modport slave (
      input  flush,
      input  lookup_valid,
      input  lookup_pc,
      input  update_valid,
      input  update_pc,
      input  update_taken,
      output predict_valid,
      output predict_taken
   );

endinterface

// File: rtl/bht_predictor.sv
// Branch history table: 2^IDX_W saturating counters indexed by pc[IDX_W+1:2].
// Lookup returns a registered prediction (counter MSB) one cycle later; update trains one
// counter per cycle; flush reloads every counter with INIT and wins over a same-cycle update.
// Optional feature macro BHT_BYPASS_EN: forward a same-cycle update/flush into the prediction.
module bht_predictor #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned INIT  = (1 << CNT_W) - 1
) (
   input logic   clk,
   input logic   reset_n,
   bht_if.slave  bus
);

   localparam int unsigned      DEPTH    = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);

   logic [CNT_W-1:0] r_table [DEPTH];
   logic             r_pred_valid;
   logic             r_pred_taken;

   logic [IDX_W-1:0] w_lk_idx;
   logic [IDX_W-1:0] w_up_idx;
   logic [CNT_W-1:0] w_up_cur;
   logic [CNT_W-1:0] w_up_next;
   logic [CNT_W-1:0] w_lk_cnt;
   logic             w_unused_pc_bits;

   assign w_lk_idx = bus.lookup_pc[IDX_W+1:2];
   assign w_up_idx = bus.update_pc[IDX_W+1:2];

   // Bits outside the index are ignored on purpose; aliasing is accepted.
   if (PC_W > IDX_W + 2) begin : g_pc_hi
      assign w_unused_pc_bits = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.update_pc[PC_W-1:IDX_W+2],
                                  bus.lookup_pc[1:0], bus.update_pc[1:0]};
   end else begin : g_pc_no_hi
      assign w_unused_pc_bits = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};
   end

   // Saturating next value of the counter addressed by the update port.
   always_comb begin
      w_up_cur  = r_table[w_up_idx];
      w_up_next = w_up_cur;
      if (bus.update_taken) begin
         if (w_up_cur != CNT_MAX) w_up_next = w_up_cur + CNT_ONE;
      end else begin
         if (w_up_cur != CNT_ZERO) w_up_next = w_up_cur - CNT_ONE;
      end
   end

   // Counter array: reset/flush reload INIT, otherwise train one entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_table[i] <= CNT_INIT;
      end else if (bus.flush) begin
         for (int i = 0; i < int'(DEPTH); i++) r_table[i] <= CNT_INIT;
      end else if (bus.update_valid) begin
         r_table[w_up_idx] <= w_up_next;
      end
   end

   // Counter value seen by the lookup port, optionally forwarding this edge's write.
   always_comb begin
      w_lk_cnt = r_table[w_lk_idx];
`ifdef BHT_BYPASS_EN
      if (bus.flush) begin
         w_lk_cnt = CNT_INIT;
      end else if (bus.update_valid && (w_up_idx == w_lk_idx)) begin
         w_lk_cnt = w_up_next;
      end
`else
      w_lk_cnt = r_table[w_lk_idx];
`endif
   end

   // Registered prediction; predict_taken holds while no lookup is presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
      end else begin
         r_pred_valid <= bus.lookup_valid;
         if (bus.lookup_valid) r_pred_taken <= w_lk_cnt[CNT_W-1];
      end
   end

   assign bus.predict_valid = r_pred_valid;
   assign bus.predict_taken = r_pred_taken;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor (CNT_W=2, IDX_W=4, PC_W=32, INIT=3).
module tb_bht_predictor;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   bht_if #(.PC_W(32)) bus ();

   bht_predictor #(
      .CNT_W (2),
      .IDX_W (4),
      .PC_W  (32),
      .INIT  (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush        = 1'b0;
      bus.lookup_valid = 1'b0;
      bus.lookup_pc    = '0;
      bus.update_valid = 1'b0;
      bus.update_pc    = '0;
      bus.update_taken = 1'b0;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic taken);
      bus.update_valid = 1'b1;
      bus.update_pc    = pc;
      bus.update_taken = taken;
      step();
      bus.update_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = pc;
      step();
      bus.lookup_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      #3;
      n_checks++;
      if (bus.predict_valid !== 1'b0 || bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b t=%b, want v=0 t=0",
                  bus.predict_valid, bus.predict_taken);
      end
      step();
      step();
      reset_n = 1'b1;
      do_lookup(32'h0);
      n_checks++;
      if (bus.predict_valid !== 1'b1 || bus.predict_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_lookup: got v=%b t=%b, want v=1 t=1",
                  bus.predict_valid, bus.predict_taken);
      end
      step();
      n_checks++;
      if (bus.predict_valid !== 1'b0 || bus.predict_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_hold: got v=%b t=%b, want v=0 t=1",
                  bus.predict_valid, bus.predict_taken);
      end
      // Lookup pending when reset hits mid-cycle must be dropped.
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = 32'h0;
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.predict_valid !== 1'b0 || bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b t=%b, want v=0 t=0",
                  bus.predict_valid, bus.predict_taken);
      end
      bus.lookup_valid = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      n_checks++;
      if (bus.predict_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_drop_lookup: got v=%b, want v=0", bus.predict_valid);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 4; i++) do_update(32'h10, 1'b0);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_down_4nt: got %b, want 0", bus.predict_taken);
      end
      do_update(32'h10, 1'b0);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_down_5nt: got %b, want 0", bus.predict_taken);
      end
      do_update(32'h10, 1'b1);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_up_1t: got %b, want 0", bus.predict_taken);
      end
      do_update(32'h10, 1'b1);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_valid !== 1'b1 || bus.predict_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_up_2t: got v=%b t=%b, want v=1 t=1",
                  bus.predict_valid, bus.predict_taken);
      end
      for (int i = 0; i < 3; i++) do_update(32'h10, 1'b1);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_up_max: got %b, want 1", bus.predict_taken);
      end
   endtask

   task automatic test_hysteresis();
      // Entry 0x10 is saturated at 3.
      do_update(32'h10, 1'b0);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL hyst_weak_taken: got %b, want 1", bus.predict_taken);
      end
      do_update(32'h10, 1'b0);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL hyst_weak_not_taken: got %b, want 0", bus.predict_taken);
      end
   endtask

   task automatic test_indexing();
      logic [31:0] pcs [4];
      logic        exp [4];
      pcs = '{32'h08, 32'h44, 32'h06, 32'h104};
      exp = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) do_update(32'h04, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_lookup(pcs[i]);
         n_checks++;
         if (bus.predict_taken !== exp[i]) begin
            n_fail++;
            $display("FAIL index_pc_%0h: got %b, want %b", pcs[i], bus.predict_taken, exp[i]);
         end
      end
   endtask

   task automatic test_conflict();
      logic exp_same;
`ifdef BHT_BYPASS_EN
      exp_same = 1'b0;
`else
      exp_same = 1'b1;
`endif
      do_update(32'h20, 1'b0);
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = 32'h20;
      do_update(32'h20, 1'b0);
      bus.lookup_valid = 1'b0;
      n_checks++;
      if (bus.predict_taken !== exp_same) begin
         n_fail++;
         $display("FAIL conflict_same_cycle: got %b, want %b", bus.predict_taken, exp_same);
      end
      do_lookup(32'h20);
      n_checks++;
      if (bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL conflict_next: got %b, want 0", bus.predict_taken);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [4];
      logic        exp [4];
      pcs = '{32'h04, 32'h08, 32'h20, 32'h0c};
      exp = '{1'b0, 1'b1, 1'b0, 1'b1};
      // Concurrent update of an unrelated entry must not disturb the lookups.
      bus.update_valid = 1'b1;
      bus.update_pc    = 32'h3c;
      bus.update_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.lookup_valid = 1'b1;
         bus.lookup_pc    = pcs[i];
         step();
         n_checks++;
         if (bus.predict_valid !== 1'b1 || bus.predict_taken !== exp[i]) begin
            n_fail++;
            $display("FAIL b2b_%0d: got v=%b t=%b, want v=1 t=%b",
                     i, bus.predict_valid, bus.predict_taken, exp[i]);
         end
      end
      idle_inputs();
      do_lookup(32'h3c);
      n_checks++;
      if (bus.predict_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_trained: got %b, want 0", bus.predict_taken);
      end
   endtask

   task automatic test_flush();
      logic [31:0] pcs [5];
      logic        exp_same;
`ifdef BHT_BYPASS_EN
      exp_same = 1'b1;
`else
      exp_same = 1'b0;
`endif
      pcs = '{32'h04, 32'h10, 32'h20, 32'h3c, 32'h08};
      for (int i = 0; i < 2; i++) do_update(32'h10, 1'b0);
      for (int i = 0; i < 2; i++) do_update(32'h20, 1'b0);
      bus.flush        = 1'b1;
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = 32'h04;
      do_update(32'h10, 1'b1);
      bus.flush        = 1'b0;
      bus.lookup_valid = 1'b0;
      n_checks++;
      if (bus.predict_taken !== exp_same) begin
         n_fail++;
         $display("FAIL flush_same_cycle: got %b, want %b", bus.predict_taken, exp_same);
      end
      for (int i = 0; i < 5; i++) begin
         do_lookup(pcs[i]);
         n_checks++;
         if (bus.predict_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pc_%0h: got %b, want 1", pcs[i], bus.predict_taken);
         end
      end
      do_update(32'h10, 1'b0);
      do_lookup(32'h10);
      n_checks++;
      if (bus.predict_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_init_value: got %b, want 1", bus.predict_taken);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_saturation();
      test_hysteresis();
      test_indexing();
      test_conflict();
      test_back_to_back();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
